// File: rtl/acc_feed_ctrl.sv
// Sequencer feeding the accumulator: frames each run with a clear pulse and a
// stop flag on the last beat, then returns the finished sum on a result port.
module acc_feed_ctrl #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned ACC_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [WIDTH-1:0] src_data,
    output logic [WIDTH-1:0] acc_in,
    output logic             acc_in_valid,
    output logic             acc_clear,
    output logic             acc_stop,
    input  logic [WIDTH-1:0] acc_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy
);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StStream,
        StDrain,
        StResult
    } state_e;

    state_e           state_q;
    logic [LEN_W-1:0] beats_left_q;
    logic [2:0]       wait_q;

    // Handshake enables are pure decodes of the state register.
    assign cmd_ready = (state_q == StIdle);
    assign src_ready = (state_q == StStream);
    assign res_valid = (state_q == StResult);
    assign busy      = (state_q != StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            beats_left_q <= '0;
            wait_q       <= '0;
            acc_in       <= '0;
            acc_in_valid <= 1'b0;
            acc_clear    <= 1'b0;
            acc_stop     <= 1'b0;
            res_data     <= '0;
        end else begin
            // Accumulator strobes are single-cycle pulses unless re-armed below.
            acc_in_valid <= 1'b0;
            acc_clear    <= 1'b0;
            acc_stop     <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        if (cmd_len == '0) begin
                            res_data <= '0;
                            state_q  <= StResult;
                        end else begin
                            beats_left_q <= cmd_len;
                            acc_clear    <= 1'b1;
                            state_q      <= StClear;
                        end
                    end
                end
                StClear: begin
                    state_q <= StStream;
                end
                StStream: begin
                    if (src_valid) begin
                        acc_in       <= src_data;
                        acc_in_valid <= 1'b1;
                        beats_left_q <= beats_left_q - 1'b1;
                        if (beats_left_q == LEN_W'(1)) begin
                            acc_stop <= 1'b1;
                            wait_q   <= 3'(ACC_LAT);
                            state_q  <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    // First drain cycle carries the last beat; wait ACC_LAT more for the sum.
                    if (wait_q == '0) begin
                        res_data <= acc_out;
                        state_q  <= StResult;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                StResult: begin
                    if (res_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_feed_ctrl.sv
// Bench for acc_feed_ctrl: directed and random runs against a behavioural
// accumulator, with expected sums and timing derived from plain arithmetic.
module tb_acc_feed_ctrl;

    localparam int WIDTH   = 32;
    localparam int LEN_W   = 16;
    localparam int ACC_LAT = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             src_valid;
    logic             src_ready;
    logic [WIDTH-1:0] src_data;
    logic [WIDTH-1:0] acc_in;
    logic             acc_in_valid;
    logic             acc_clear;
    logic             acc_stop;
    logic [WIDTH-1:0] acc_out;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             busy;

    acc_feed_ctrl #(
        .WIDTH  (WIDTH),
        .LEN_W  (LEN_W),
        .ACC_LAT(ACC_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_len     (cmd_len),
        .src_valid   (src_valid),
        .src_ready   (src_ready),
        .src_data    (src_data),
        .acc_in      (acc_in),
        .acc_in_valid(acc_in_valid),
        .acc_clear   (acc_clear),
        .acc_stop    (acc_stop),
        .acc_out     (acc_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Behavioural accumulator: sum register followed by ACC_LAT-1 delay stages.
    logic [WIDTH-1:0] acc_pipe [ACC_LAT];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ACC_LAT; i++) acc_pipe[i] <= '0;
        end else begin
            if (acc_clear) acc_pipe[0] <= '0;
            else if (acc_in_valid) acc_pipe[0] <= acc_pipe[0] + acc_in;
            for (int i = 1; i < ACC_LAT; i++) acc_pipe[i] <= acc_pipe[i-1];
        end
    end
    assign acc_out = acc_pipe[ACC_LAT-1];

    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    logic [31:0] ops [16];
    logic [31:0] last_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk_rst_vals(input string tag);
        chkb({tag, ".cmd_ready"}, cmd_ready, 1'b1);
        chkb({tag, ".src_ready"}, src_ready, 1'b0);
        chk ({tag, ".acc_in"}, acc_in, 32'h0);
        chkb({tag, ".acc_in_valid"}, acc_in_valid, 1'b0);
        chkb({tag, ".acc_clear"}, acc_clear, 1'b0);
        chkb({tag, ".acc_stop"}, acc_stop, 1'b0);
        chkb({tag, ".res_valid"}, res_valid, 1'b0);
        chk ({tag, ".res_data"}, res_data, 32'h0);
        chkb({tag, ".busy"}, busy, 1'b0);
    endtask

    // One command from acceptance to result handshake, checked every cycle.
    task automatic do_run(input string name, input int len, input int gap_min,
                          input int gap_max, input int res_delay);
        logic [31:0] sum;
        logic        prev_hs;
        int          t0;
        int          t_last;
        sum = '0;
        for (int i = 0; i < len; i++) sum = sum + ops[i];
        chkb({name, ".accept"}, cmd_ready, 1'b1);
        t0 = cyc;
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        tick();
        cmd_valid = 1'b0;
        cmd_len   = LEN_W'($urandom);
        if (len == 0) begin
            chkb({name, ".z_res_valid"}, res_valid, 1'b1);
            chk ({name, ".z_res_data"}, res_data, 32'h0);
            chkb({name, ".z_clear"}, acc_clear, 1'b0);
            chkb({name, ".z_busy"}, busy, 1'b1);
        end else begin
            chkb({name, ".clear"}, acc_clear, 1'b1);
            chkb({name, ".clr_src_ready"}, src_ready, 1'b0);
            chkb({name, ".clr_in_valid"}, acc_in_valid, 1'b0);
            chkb({name, ".clr_busy"}, busy, 1'b1);
            tick();
            prev_hs = 1'b0;
            for (int i = 0; i < len; i++) begin
                int gap;
                gap = (i == 0) ? 0 : int'($urandom_range(gap_max, gap_min));
                for (int g = 0; g <= gap; g++) begin
                    chkb($sformatf("%s.b%0d.src_ready", name, i), src_ready, 1'b1);
                    chkb($sformatf("%s.b%0d.clear", name, i), acc_clear, 1'b0);
                    chkb($sformatf("%s.b%0d.in_valid", name, i), acc_in_valid, prev_hs);
                    chkb($sformatf("%s.b%0d.stop", name, i), acc_stop, 1'b0);
                    chk ($sformatf("%s.b%0d.acc_in", name, i), acc_in, last_in);
                    src_valid = (g == gap);
                    src_data  = (g == gap) ? ops[i] : $urandom;
                    tick();
                    prev_hs = (g == gap);
                    if (g == gap) last_in = ops[i];
                end
                src_valid = 1'b0;
            end
            t_last = cyc - 1;
            chkb({name, ".last_valid"}, acc_in_valid, 1'b1);
            chkb({name, ".last_stop"}, acc_stop, 1'b1);
            chk ({name, ".last_acc_in"}, acc_in, last_in);
            chkb({name, ".last_src_ready"}, src_ready, 1'b0);
            chkb({name, ".last_clear"}, acc_clear, 1'b0);
            for (int d = 0; d < ACC_LAT; d++) begin
                tick();
                chkb($sformatf("%s.drain%0d.res_valid", name, d), res_valid, 1'b0);
                chkb($sformatf("%s.drain%0d.in_valid", name, d), acc_in_valid, 1'b0);
                chkb($sformatf("%s.drain%0d.stop", name, d), acc_stop, 1'b0);
                chkb($sformatf("%s.drain%0d.busy", name, d), busy, 1'b1);
            end
            tick();
            chk({name, ".res_latency"}, 32'(cyc - t_last), 32'(2 + ACC_LAT));
            chkb({name, ".res_valid"}, res_valid, 1'b1);
            chk ({name, ".res_data"}, res_data, sum);
            if (gap_max == 0) chk({name, ".total_cycles"}, 32'(cyc - t0), 32'(len + 3 + ACC_LAT));
        end
        for (int d = 0; d <= res_delay; d++) begin
            cmd_valid = 1'b1;
            cmd_len   = LEN_W'($urandom);
            res_ready = (d == res_delay);
            chkb($sformatf("%s.r%0d.res_valid", name, d), res_valid, 1'b1);
            chk ($sformatf("%s.r%0d.res_data", name, d), res_data, sum);
            chkb($sformatf("%s.r%0d.cmd_ready", name, d), cmd_ready, 1'b0);
            chkb($sformatf("%s.r%0d.clear", name, d), acc_clear, 1'b0);
            chkb($sformatf("%s.r%0d.in_valid", name, d), acc_in_valid, 1'b0);
            chkb($sformatf("%s.r%0d.stop", name, d), acc_stop, 1'b0);
            tick();
        end
        res_ready = 1'b0;
        cmd_valid = 1'b0;
        chkb({name, ".idle_cmd_ready"}, cmd_ready, 1'b1);
        chkb({name, ".idle_res_valid"}, res_valid, 1'b0);
        chkb({name, ".idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        src_valid = 1'b0;
        src_data  = '0;
        res_ready = 1'b0;
        last_in   = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_rst_vals($sformatf("reset%0d", c));
        end
        rst = 1'b0;
        tick();
        chk_rst_vals("post_reset");

        ops[0] = 32'd1; ops[1] = 32'd2; ops[2] = 32'd3; ops[3] = 32'd4;
        do_run("len4", 4, 0, 0, 0);

        ops[0] = 32'h10; ops[1] = 32'h20; ops[2] = 32'h30;
        do_run("len3_gaps", 3, 2, 2, 0);

        do_run("len0", 0, 0, 0, 0);

        ops[0] = 32'hdead_beef; ops[1] = 32'h1234_5678;
        do_run("backpressure", 2, 0, 0, 5);

        // Abort a 5-beat run after two beats with an asynchronous reset.
        for (int i = 0; i < 5; i++) ops[i] = 32'(i + 100);
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(5);
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            src_valid = 1'b1;
            src_data  = ops[i];
            tick();
        end
        src_valid = 1'b0;
        chkb("abort.mid_busy", busy, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        last_in = '0;
        chk_rst_vals("abort.async");
        tick();
        chk_rst_vals("abort.held");
        rst = 1'b0;
        tick();
        ops[0] = 32'd7; ops[1] = 32'd8;
        do_run("after_abort", 2, 0, 0, 0);

        for (int r = 0; r < 20; r++) begin
            int len;
            len = int'($urandom_range(10, 0));
            for (int i = 0; i < len; i++) ops[i] = $urandom;
            do_run($sformatf("rand%0d", r), len, 0, 3, int'($urandom_range(3, 0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/acc_feed_ctrl.md
# acc_feed_ctrl

Sequencing front end for the PuDianNao accumulator. Accepts a command giving a vector length, pulls that many operand words from an upstream valid/ready source, and drives them into the accumulator one per beat. It frames each run with a clear pulse before the first beat and a stop flag on the last beat, samples the finished sum, and returns it on a valid/ready result port.

## Interface
- WIDTH, 32, operand/result width
- LEN_W, 16, width of length field
- ACC_LAT, 1, cycles from an accumulator input beat (acc_in_valid high) to its effect on acc_out; range 1..7
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_len  in  LEN_W  number of operands in this run; 0 allowed
- src_valid  in  1  operand offered
- src_ready  out  1  high only in STREAM
- src_data  in  WIDTH  operand
- acc_in  out  WIDTH  registered operand to accumulator
- acc_in_valid  out  1  one-cycle pulse per beat
- acc_clear  out  1  one-cycle pulse clearing accumulator
- acc_stop  out  1  high with the final beat only
- acc_out  in  WIDTH  accumulator sum
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_data  out  WIDTH  captured sum
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, RESULT.
- **IDLE**
  - On cmd_valid&cmd_ready with cmd_len≠0: latch the length into beats_left and go to CLEAR.
  - With cmd_len=0: load res_data=0 and go directly to RESULT. No clear, beat or stop is issued.
- **CLEAR**
  - Registered acc_clear=1 for exactly this one cycle, then go to STREAM.
- **STREAM**
  - src_ready=1.
  - Each src_valid&src_ready handshake registers acc_in=src_data and acc_in_valid=1 for the next cycle, and decrements beats_left.
  - When beats_left=1 at the handshake, also register acc_stop=1 for the next cycle and go to DRAIN.
  - With no handshake, acc_in_valid=0 and acc_in holds its last value.
- **DRAIN**
  - Wait counter loaded with ACC_LAT. Capture acc_out into res_data at the clock edge ending cycle L+1+ACC_LAT (L is the final handshake cycle), then go to RESULT.
  - src_ready=0.
- **RESULT**
  - res_valid=1 and res_data stable until res_valid&res_ready, then go to IDLE.
- Arithmetic: no computation in this block; operands are passed through unmodified. beats_left is LEN_W bits, so the maximum run is 2^LEN_W−1 beats.
- cmd_len is sampled only at acceptance; changes afterwards are ignored.
- rst at any time: return to IDLE immediately and drop the in-flight run. The next command begins with a fresh acc_clear.

## Timing
- Reset values: cmd_ready=1, src_ready=0, acc_in=0, acc_in_valid=0, acc_clear=0, acc_stop=0, res_valid=0, res_data=0, busy=0.
- Command accepted in cycle T:
  - acc_clear=1 in T+1.
  - src_ready=1 from T+2.
  - Earliest first beat handshake at T+2, appearing on acc_in_valid at T+3.
- Beat handshake in cycle k: acc_in/acc_in_valid in k+1.
- Final beat handshake in cycle L:
  - acc_stop and acc_in_valid both high in L+1.
  - res_valid rises at L+2+ACC_LAT.
- Full-rate streaming: a length-N run occupies N consecutive acc_in_valid cycles.
- len=0: accepted in T, res_valid=1 from T+1.
- Result back-to-back: res handshake in cycle R puts the block in IDLE at R+1, and the next command is accepted no earlier than R+1.
- acc_clear, acc_in_valid and acc_stop are never high in the same cycle as each other, with one exception: acc_in_valid and acc_stop coincide on the final beat.

## Test plan
- Reset: hold rst for 3 cycles → all outputs at reset values and cmd_ready=1 throughout.
- len=4, src_data 1,2,3,4 back-to-back, behavioural accumulator with ACC_LAT=1:
  - acc_clear at T+1.
  - acc_in_valid T+3..T+6, acc_stop only at T+6.
  - res_valid at T+8 with res_data=10.
- len=3, operands 0x10,0x20,0x30 with src_valid low for 2 cycles between beats → acc_in_valid only on cycles following handshakes, and res_data=0x60.
- len=0 → res_valid at T+1 with res_data=0; acc_clear, acc_in_valid and acc_stop never asserted.
- Result backpressure: res_ready low for 5 cycles while cmd_valid=1 → res_data held, cmd_ready=0, no new command accepted; handshake in cycle R → command accepted at R+1.
- Reset mid-run: assert rst after 2 of 5 beats → outputs return to reset values immediately; the next len=2 run (7,8) clears and returns res_data=15.
